// File: rtl/uart_boot_loader.sv
// Purpose: UART program loader; receives a length-prefixed, XOR-checksummed image
//          and writes it word-by-word into instruction memory, holding the core in reset.
// Latency: imem_we 1 cycle after the rx_valid of a word's 4th byte; ACK/NAK start bit
//          1 cycle after the decision; cpu_resetn rises 1 cycle after the ACK stop bit.
// Backpressure: none; byte rate is bounded by the UART, and bytes arriving while
//               ACK/NAK is being sent (or after a successful load) are dropped.
// Ports:
//   CLK100MHZ, CPU_RESETN         : clock, async active-low reset
//   uart_txd_in / uart_rxd_out    : serial from / to host, 8N1, idle high
//   imem_we, imem_addr, imem_wdata: one-cycle word write into instruction memory
//   cpu_resetn                    : core reset, released after a good image
//   busy, error                   : load in progress / last load failed (sticky)
module uart_boot_loader #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 12
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              uart_txd_in,
  output logic              uart_rxd_out,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_resetn,
  output logic              busy,
  output logic              error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [7:0]    ACK_BYTE  = 8'h06;
  localparam logic [7:0]    NAK_BYTE  = 8'h15;
  // Largest legal word count; 33 bits so ADDR_W up to 32 still compares correctly.
  localparam logic [32:0]   MAX_WORDS = 33'd1 << ADDR_W;

  // ---------------------------------------------------------------- RX path
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state, rx_state_nxt;
  logic            rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bitn;
  logic [7:0]      rx_byte;
  logic            rx_valid, rx_ferr;
  logic            rx_tick;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_txd_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_tick = (rx_cnt == BIT_LAST);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) rx_state <= RX_IDLE;
    else             rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      // Edge-triggered so a line held low after a framing error is not re-read as a start.
      RX_IDLE:  if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
      // Line back high at mid start bit: treat as a glitch.
      RX_START: if (rx_cnt == HALF_LAST) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bitn == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rx_cnt   <= '0;
      rx_bitn  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (rx_state == RX_IDLE || rx_state_nxt != rx_state || rx_tick) rx_cnt <= '0;
      else                                                          rx_cnt <= rx_cnt + CNT_ONE;
      if (rx_state == RX_START) rx_bitn <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_byte <= {rx_sync, rx_byte[7:1]};
        rx_bitn <= rx_bitn + 3'd1;
      end
      if (rx_state == RX_STOP && rx_tick) begin
        rx_valid <= rx_sync;
        rx_ferr  <= ~rx_sync;
      end
    end
  end

  // ---------------------------------------------------------------- TX path
  logic            tx_go;
  logic [7:0]      tx_byte;
  logic            tx_busy;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bitn;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]      tx_shift;  // remaining data bits followed by the stop bit
  logic            tx_done;

  assign tx_done = tx_busy && (tx_cnt == BIT_LAST) && (tx_bitn == 4'd9);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      tx_busy      <= 1'b0;
      tx_cnt       <= '0;
      tx_bitn      <= '0;
      tx_shift     <= '1;
      uart_rxd_out <= 1'b1;
    end else if (tx_go) begin
      tx_busy      <= 1'b1;
      tx_cnt       <= '0;
      tx_bitn      <= '0;
      tx_shift     <= {1'b1, tx_byte};
      uart_rxd_out <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bitn == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          uart_rxd_out <= tx_shift[0];
          tx_shift     <= {1'b1, tx_shift[8:1]};
          tx_bitn      <= tx_bitn + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------- Loader FSM
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_ACK, S_DONE, S_ERR} state_t;

  state_t          state, state_nxt;
  logic [31:0]     len_q;
  logic [1:0]      cnt;
  logic [ADDR_W:0] idx;       // one bit wider so N = 2**ADDR_W is reachable
  logic [7:0]      csum;
  logic [23:0]     word_q;
  logic [31:0]     len_full;
  logic            len_bad;
  logic            last_word;

  assign len_full  = {rx_byte, len_q[23:0]};
  assign len_bad   = (len_full == 32'd0) || ({1'b0, len_full} > MAX_WORDS);
  assign last_word = ((33'(idx) + 33'd1) == {1'b0, len_q});

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= S_LEN;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_go     = 1'b0;
    tx_byte   = NAK_BYTE;
    case (state)
      S_LEN: begin
        if (rx_ferr)                   state_nxt = S_ERR;
        else if (rx_valid && cnt == 2'd3) state_nxt = len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (rx_ferr)                                   state_nxt = S_ERR;
        else if (rx_valid && cnt == 2'd3 && last_word) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (rx_ferr)       state_nxt = S_ERR;
        else if (rx_valid) state_nxt = (rx_byte == csum) ? S_ACK : S_ERR;
      end
      S_ACK:   if (tx_done) state_nxt = S_DONE;
      S_ERR:   if (tx_done) state_nxt = S_LEN;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_LEN;
    endcase
    // The response byte launches on the decision cycle so the start bit appears one cycle later.
    if (state_nxt != state && (state_nxt == S_ACK || state_nxt == S_ERR)) begin
      tx_go   = 1'b1;
      tx_byte = (state_nxt == S_ACK) ? ACK_BYTE : NAK_BYTE;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      len_q      <= '0;
      cnt        <= '0;
      idx        <= '0;
      csum       <= '0;
      word_q     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_resetn <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_LEN: begin
            case (cnt)
              2'd0:    len_q[7:0]   <= rx_byte;
              2'd1:    len_q[15:8]  <= rx_byte;
              2'd2:    len_q[23:16] <= rx_byte;
              default: len_q[31:24] <= rx_byte;
            endcase
            cnt <= cnt + 2'd1;
            if (cnt == 2'd0) begin
              busy  <= 1'b1;
              error <= 1'b0;
            end
          end
          S_DATA: begin
            csum <= csum ^ rx_byte;
            cnt  <= cnt + 2'd1;
            case (cnt)
              2'd0: word_q[7:0]   <= rx_byte;
              2'd1: word_q[15:8]  <= rx_byte;
              2'd2: word_q[23:16] <= rx_byte;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= idx[ADDR_W-1:0];
                imem_wdata <= {rx_byte, word_q};
                idx        <= idx + (ADDR_W+1)'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
      // Every state change restarts byte counting; a fresh image also restarts idx/csum.
      if (state_nxt != state) begin
        cnt <= '0;
        if (state_nxt == S_DATA) begin
          idx  <= '0;
          csum <= '0;
        end
      end
      if (state_nxt == S_ERR && state != S_ERR) error <= 1'b1;
      if (tx_done && (state == S_ACK || state == S_ERR)) busy <= 1'b0;
      cpu_resetn <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Purpose: scoreboard bench for uart_boot_loader at 10 clocks per bit, ADDR_W = 2.
// Latency: stimulus pushes expected writes / response bytes; monitors check them as they appear.
// Backpressure: none; the bench paces bytes at the UART rate.
module tb_uart_boot_loader;

  localparam int CPB = 10;

  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN;
  logic        uart_txd_in;
  logic        uart_rxd_out;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_resetn;
  logic        busy;
  logic        error;

  always #5 CLK100MHZ = ~CLK100MHZ;

  uart_boot_loader #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000),
    .ADDR_W  (2)
  ) dut (
    .CLK100MHZ   (CLK100MHZ),
    .CPU_RESETN  (CPU_RESETN),
    .uart_txd_in (uart_txd_in),
    .uart_rxd_out(uart_rxd_out),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_resetn  (cpu_resetn),
    .busy        (busy),
    .error       (error)
  );

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic push_wr(input logic [1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  // ---------------- write monitor
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK100MHZ);
      if (CPU_RESETN === 1'b1 && imem_we === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", imem_addr, imem_wdata);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(e.addr));
          check("wr_data", imem_wdata, e.data);
        end
      end
    end
  end

  // ---------------- TX byte monitor (samples mid-bit)
  initial begin
    logic [7:0] b;
    logic       stop_b;
    forever begin
      @(negedge CLK100MHZ);
      if (uart_rxd_out === 1'b0) begin
        repeat (CPB/2) @(negedge CLK100MHZ);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK100MHZ);
          b[i] = uart_rxd_out;
        end
        repeat (CPB) @(negedge CLK100MHZ);
        stop_b = uart_rxd_out;
        if (exp_tx.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_tx: byte 0x%02h, none expected", b);
        end else begin
          check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
          check("tx_stop", 32'(stop_b), 32'd1);
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge CLK100MHZ);
    uart_txd_in = 1'b0;
    repeat (CPB) @(negedge CLK100MHZ);
    for (int i = 0; i < 8; i++) begin
      uart_txd_in = b[i];
      repeat (CPB) @(negedge CLK100MHZ);
    end
    uart_txd_in = stop_bit;
    repeat (CPB) @(negedge CLK100MHZ);
    uart_txd_in = 1'b1;
    repeat (2*CPB) @(negedge CLK100MHZ);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  // Wait for the response to finish; cpu_resetn must change on the same edge busy falls.
  task automatic wait_idle(input string name, input logic exp_rstn, input logic exp_err);
    int k;
    k = 0;
    check({name, "_busy_before"}, 32'(busy), 32'd1);
    while (busy !== 1'b0 && k < 400) begin
      @(negedge CLK100MHZ);
      k++;
    end
    if (k >= 400) begin
      n_checks++;
      $display("FAIL %s_timeout: busy still 0x%0h after 400 cycles, required 0x0", name, busy);
    end else begin
      check({name, "_cpu_resetn"}, 32'(cpu_resetn), 32'(exp_rstn));
      check({name, "_error"}, 32'(error), 32'(exp_err));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_txd"},        32'(uart_rxd_out), 32'd1);
    check({name, "_imem_we"},    32'(imem_we),      32'd0);
    check({name, "_imem_addr"},  32'(imem_addr),    32'd0);
    check({name, "_imem_wdata"}, imem_wdata,        32'd0);
    check({name, "_cpu_resetn"}, 32'(cpu_resetn),   32'd0);
    check({name, "_busy"},       32'(busy),         32'd0);
    check({name, "_error"},      32'(error),        32'd0);
  endtask

  // ---------------- watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence
  initial begin
    uart_txd_in = 1'b1;
    CPU_RESETN  = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
    check_reset_outputs("reset");
    CPU_RESETN = 1'b1;
    repeat (5) @(negedge CLK100MHZ);

    // Short low pulse on an idle line must not become a byte.
    uart_txd_in = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
    uart_txd_in = 1'b1;
    repeat (40) @(negedge CLK100MHZ);
    check("glitch_busy", 32'(busy), 32'd0);

    // Zero length: NAK, no writes.
    exp_tx.push_back(8'h15);
    send_word(32'd0);
    wait_idle("len0", 1'b0, 1'b1);

    // N = 5 exceeds the 4-word memory: NAK.
    exp_tx.push_back(8'h15);
    send_word(32'd5);
    wait_idle("oversize", 1'b0, 1'b1);

    // Bad checksum: both words still written, then NAK. Correct XOR is 0x31.
    send_word(32'd2);
    check("badcs_error_cleared", 32'(error), 32'd0);
    push_wr(2'd0, 32'h0000_0013);
    push_wr(2'd1, 32'hDEAD_BEEF);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
    exp_tx.push_back(8'h15);
    send_byte(8'h00, 1'b1);
    wait_idle("badcs", 1'b0, 1'b1);

    // Framing error in the second word: first word written, second never is.
    send_word(32'd2);
    push_wr(2'd0, 32'h0000_0013);
    send_word(32'h0000_0013);
    send_byte(8'hEF, 1'b1);
    exp_tx.push_back(8'h15);
    send_byte(8'hBE, 1'b0);
    wait_idle("framing", 1'b0, 1'b1);

    // Good image: ACK, core released, error cleared.
    send_word(32'd2);
    check("good_error_cleared", 32'(error), 32'd0);
    check("good_busy", 32'(busy), 32'd1);
    push_wr(2'd0, 32'h0000_0013);
    push_wr(2'd1, 32'hDEAD_BEEF);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
    exp_tx.push_back(8'h06);
    send_byte(8'h31, 1'b1);
    wait_idle("good", 1'b1, 1'b0);

    // After a successful load further bytes are ignored.
    send_byte(8'h55, 1'b1);
    repeat (20) @(negedge CLK100MHZ);
    check("done_busy", 32'(busy), 32'd0);
    check("done_cpu_resetn", 32'(cpu_resetn), 32'd1);

    CPU_RESETN = 1'b0;
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    repeat (5) @(negedge CLK100MHZ);
    check("rst_after_done_cpu_resetn", 32'(cpu_resetn), 32'd0);

    // Reset after 6 payload bytes of a 4-word image.
    send_word(32'd4);
    push_wr(2'd0, 32'h1122_3344);
    send_word(32'h1122_3344);
    send_byte(8'hA5, 1'b1);
    send_byte(8'hA5, 1'b1);
    CPU_RESETN = 1'b0;
    repeat (2) @(negedge CLK100MHZ);
    check_reset_outputs("midload");
    CPU_RESETN = 1'b1;
    repeat (5) @(negedge CLK100MHZ);

    // Full-capacity image N = 4; XOR of payload bytes is 0x44 ^ 0x13 = 0x57.
    send_word(32'd4);
    push_wr(2'd0, 32'h1122_3344);
    push_wr(2'd1, 32'hA5A5_A5A5);
    push_wr(2'd2, 32'h0000_0013);
    push_wr(2'd3, 32'hFFFF_FFFF);
    send_word(32'h1122_3344);
    send_word(32'hA5A5_A5A5);
    send_word(32'h0000_0013);
    send_word(32'hFFFF_FFFF);
    exp_tx.push_back(8'h06);
    send_byte(8'h57, 1'b1);
    wait_idle("full", 1'b1, 1'b0);

    repeat (20) @(negedge CLK100MHZ);
    check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    check("tx_outstanding", 32'(exp_tx.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
